// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the core's pipeline stages.
package cpu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        ERR
    } fetch_state_t;

    // Instruction fetches must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read port (request/grant/response).
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) ();

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_timeout.sv
// fetch_timeout: 8-bit cycle counter that flags the last cycle a fetch may
// spend waiting on memory.
module fetch_timeout
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count;

    // Count cycles spent waiting on memory, restarting with each new fetch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // Asserted in the cycle whose closing edge brings the count to the limit,
    // so the abort lands exactly TIMEOUT cycles after the fetch began.
    assign expired = enable && ((count + 8'd1) == LIMIT);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, issues one memory read
// per fetch request and reports the fetched word, or a NOP on misalignment
// or memory timeout.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_start,
    input  logic            pc_wren,
    input  logic [XLEN-1:0] next_pc,
    fetch_unit_if.master    imem,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     inst,
    output logic            inst_valid,
    output logic            fetch_done,
    output logic            fetch_err
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic            start_ok;
    logic            misaligned;
    logic            expired;
    logic            busy_en;
    logic            returning;
    logic            accept_rsp;
    logic            enter_err;
    logic            abort_outstanding;
    logic            pending;
    logic            drop;
    logic [XLEN-1:0] pending_pc;
    logic [XLEN-1:0] fetch_addr;

    // A PC write in the same cycle as the fetch request is forwarded.
    assign fetch_addr = pc_wren ? next_pc : pc;
    assign start_ok   = fetch_start && (state == IDLE);
    assign misaligned = is_misaligned(fetch_addr[1:0]);
    assign busy_en    = (state == REQ) || (state == WAIT);
    assign returning  = (state == DONE) || (state == ERR);
    // A response owed to an aborted fetch must not be taken as ours.
    assign accept_rsp = (state == WAIT) && imem.imem_rvalid && !drop;
    assign enter_err  = (state != ERR) && (state_next == ERR);
    // Aborting after the memory accepted the request leaves a response in flight.
    assign abort_outstanding = ((state == WAIT) && (state_next == ERR)) ||
                               ((state == REQ) && expired && imem.imem_gnt);

    assign imem.imem_req = (state == REQ);
    assign fetch_done    = returning;

    fetch_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start_ok),
        .enable  (busy_en),
        .expired (expired)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: memory data arriving in the final allowed cycle wins over the timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fetch_start) begin
                    state_next = misaligned ? ERR : REQ;
                end
            end
            REQ: begin
                if (expired) begin
                    state_next = ERR;
                end else if (imem.imem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (accept_rsp) begin
                    state_next = DONE;
                end else if (expired) begin
                    state_next = ERR;
                end
            end
            DONE, ERR: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // PC update: immediate when idle, deferred to the return to IDLE while busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= RESET_PC;
        end else if (state == IDLE) begin
            if (pc_wren) begin
                pc <= next_pc;
            end
        end else if (returning) begin
            if (pc_wren) begin
                pc <= next_pc;
            end else if (pending) begin
                pc <= pending_pc;
            end
            pending <= 1'b0;
        end else if (pc_wren) begin
            pending    <= 1'b1;
            pending_pc <= next_pc;
        end
    end

    // Latch the fetch address and record each fetch's outcome for the IF/ID register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem.imem_addr <= RESET_PC;
            inst           <= NOP_INST;
            inst_valid     <= 1'b0;
            fetch_err      <= 1'b0;
        end else begin
            if (start_ok) begin
                imem.imem_addr <= fetch_addr;
                inst_valid     <= 1'b0;
                fetch_err      <= 1'b0;
            end
            if (accept_rsp) begin
                inst       <= imem.imem_rdata;
                inst_valid <= 1'b1;
            end
            if (enter_err) begin
                inst       <= NOP_INST;
                inst_valid <= 1'b1;
                fetch_err  <= 1'b1;
            end
        end
    end

    // Track a response still owed to an aborted fetch until it arrives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop <= 1'b0;
        end else if (abort_outstanding) begin
            drop <= 1'b1;
        end else if (imem.imem_rvalid) begin
            drop <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized fetches checked against a
// transaction-level model of fetch latency, PC update and error handling.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int          TMO = 10;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b1;
    logic        fetch_start = 1'b0;
    logic        pc_wren     = 1'b0;
    logic [31:0] next_pc     = '0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_done;
    logic        fetch_err;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_pc   = '0;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fetch_start (fetch_start),
        .pc_wren     (pc_wren),
        .next_pc     (next_pc),
        .imem        (bus),
        .pc          (pc),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .fetch_done  (fetch_done),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Cycle (counted from the fetch_start edge) in which fetch_done is seen.
    // Grant after g extra request cycles, data r cycles after the one-cycle minimum.
    function automatic int exp_done(input int g, input int r, input logic mis);
        if (mis) return 1;
        if (g + 2 + r <= TMO) return g + 3 + r;
        return TMO + 1;
    endfunction

    function automatic int exp_reqs(input int g, input logic mis);
        if (mis) return 0;
        return (g + 1 < TMO) ? g + 1 : TMO;
    endfunction

    function automatic logic exp_err(input int g, input int r, input logic mis);
        return mis || (g + 2 + r > TMO);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_pc(input logic [31:0] val);
        pc_wren = 1'b1;
        next_pc = val;
        @(posedge clk); #1;
        pc_wren = 1'b0;
        m_pc    = val;
    endtask

    // Issue one fetch and play the memory side; return what was observed.
    task automatic run_fetch(
        input  int g, input int r, input logic sw, input logic [31:0] snpc,
        input  int wc, input logic [31:0] wnpc, input logic [31:0] data,
        output int done_cyc, output int done_n, output int req_n, output logic addr_ok,
        output logic [31:0] addr_obs, output logic [31:0] inst_obs, output logic valid_obs,
        output logic err_obs, output logic [31:0] pc_done);
        int resp_at;
        resp_at  = -1;
        done_cyc = -1;
        done_n   = 0;
        req_n    = 0;
        addr_ok  = 1'b1;
        addr_obs = '0;
        inst_obs = '0;
        valid_obs = 1'b0;
        err_obs  = 1'b0;
        pc_done  = '0;
        fetch_start = 1'b1;
        pc_wren     = sw;
        next_pc     = snpc;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clk); #1;
            fetch_start     = 1'b0;
            pc_wren         = 1'b0;
            bus.imem_gnt    = 1'b0;
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
            if (fetch_done) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc  = cyc;
                    inst_obs  = inst;
                    valid_obs = inst_valid;
                    err_obs   = fetch_err;
                    pc_done   = pc;
                end
            end
            if (done_cyc >= 0 && cyc > done_cyc && cyc > resp_at && cyc > wc) break;
            if (cyc == wc) begin
                pc_wren = 1'b1;
                next_pc = wnpc;
            end
            if (bus.imem_req) begin
                req_n++;
                if (req_n == 1) addr_obs = bus.imem_addr;
                else if (bus.imem_addr !== addr_obs) addr_ok = 1'b0;
                if (req_n == g + 1) begin
                    bus.imem_gnt = 1'b1;
                    resp_at = cyc + 1 + r;
                end
            end
            if (cyc == resp_at) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = data;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #1 reset_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h, want %h", pc, 32'h0); end
        n_cmp++; if (inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h, want %h", inst, NOP); end
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h, want %h", bus.imem_addr, 32'h0); end
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, want 0", bus.imem_req); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, want 0", inst_valid); end
        n_cmp++; if (fetch_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, want 0", fetch_done); end
        n_cmp++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, want 0", fetch_err); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        m_pc = 32'h0;
    endtask

    task automatic test_basic;
        int dc, dn, rn; logic ao, vo, eo; logic [31:0] aa, io, pd;
        set_pc(32'h100);
        n_cmp++; if (pc !== 32'h100) begin n_fail++; $display("FAIL basic_pc_load: got %h, want %h", pc, 32'h100); end
        run_fetch(0, 0, 1'b0, '0, 0, '0, 32'h00A0_0093, dc, dn, rn, ao, aa, io, vo, eo, pd);
        n_cmp++; if (aa !== 32'h100) begin n_fail++; $display("FAIL basic_addr: got %h, want %h", aa, 32'h100); end
        n_cmp++; if (rn !== 1) begin n_fail++; $display("FAIL basic_req_cycles: got %0d, want 1", rn); end
        n_cmp++; if (dc !== 3) begin n_fail++; $display("FAIL basic_done_cycle: got %0d, want 3", dc); end
        n_cmp++; if (dn !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d, want 1", dn); end
        n_cmp++; if (io !== 32'h00A0_0093) begin n_fail++; $display("FAIL basic_inst: got %h, want %h", io, 32'h00A0_0093); end
        n_cmp++; if (vo !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b, want 1", vo); end
        n_cmp++; if (eo !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b, want 0", eo); end
        n_cmp++; if (inst !== 32'h00A0_0093 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL basic_hold: got %h/%b, want %h/1", inst, inst_valid, 32'h00A0_0093); end
    endtask

    task automatic test_delayed;
        int dc, dn, rn; logic ao, vo, eo; logic [31:0] aa, io, pd;
        run_fetch(4, 1, 1'b0, '0, 0, '0, 32'h1234_5678, dc, dn, rn, ao, aa, io, vo, eo, pd);
        n_cmp++; if (rn !== 5) begin n_fail++; $display("FAIL delayed_req_cycles: got %0d, want 5", rn); end
        n_cmp++; if (ao !== 1'b1) begin n_fail++; $display("FAIL delayed_addr_stable: got %b, want 1", ao); end
        n_cmp++; if (dc !== 8) begin n_fail++; $display("FAIL delayed_done_cycle: got %0d, want 8", dc); end
        n_cmp++; if (io !== 32'h1234_5678) begin n_fail++; $display("FAIL delayed_inst: got %h, want %h", io, 32'h1234_5678); end
    endtask

    task automatic test_pending_pc;
        int dc, dn, rn; logic ao, vo, eo; logic [31:0] aa, io, pd, old;
        old = m_pc;
        run_fetch(1, 2, 1'b0, '0, 3, 32'h200, 32'hCAFE_0013, dc, dn, rn, ao, aa, io, vo, eo, pd);
        n_cmp++; if (pd !== old) begin n_fail++; $display("FAIL pending_pc_at_done: got %h, want %h", pd, old); end
        n_cmp++; if (pc !== 32'h200) begin n_fail++; $display("FAIL pending_pc_after: got %h, want %h", pc, 32'h200); end
        m_pc = 32'h200;
        run_fetch(0, 0, 1'b0, '0, 0, '0, 32'h0000_0093, dc, dn, rn, ao, aa, io, vo, eo, pd);
        n_cmp++; if (aa !== 32'h200) begin n_fail++; $display("FAIL pending_next_addr: got %h, want %h", aa, 32'h200); end
    endtask

    task automatic test_misaligned;
        int dc, dn, rn; logic ao, vo, eo; logic [31:0] aa, io, pd;
        run_fetch(0, 0, 1'b1, 32'h102, 0, '0, 32'h1111_1111, dc, dn, rn, ao, aa, io, vo, eo, pd);
        n_cmp++; if (rn !== 0) begin n_fail++; $display("FAIL mis_req_cycles: got %0d, want 0", rn); end
        n_cmp++; if (dc !== 1) begin n_fail++; $display("FAIL mis_done_cycle: got %0d, want 1", dc); end
        n_cmp++; if (eo !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b, want 1", eo); end
        n_cmp++; if (io !== NOP) begin n_fail++; $display("FAIL mis_inst: got %h, want %h", io, NOP); end
        n_cmp++; if (pc !== 32'h102) begin n_fail++; $display("FAIL mis_pc: got %h, want %h", pc, 32'h102); end
        set_pc(32'h300);
    endtask

    task automatic test_timeout;
        int dc, dn, rn; logic ao, vo, eo; logic [31:0] aa, io, pd;
        run_fetch(30, 0, 1'b0, '0, 0, '0, 32'h2222_2222, dc, dn, rn, ao, aa, io, vo, eo, pd);
        n_cmp++; if (dc !== TMO + 1) begin n_fail++; $display("FAIL tmo_done_cycle: got %0d, want %0d", dc, TMO + 1); end
        n_cmp++; if (eo !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b, want 1", eo); end
        n_cmp++; if (rn !== TMO) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d, want %0d", rn, TMO); end
        n_cmp++; if (io !== NOP) begin n_fail++; $display("FAIL tmo_inst: got %h, want %h", io, NOP); end
        // grant in the last allowed cycle: aborted, late response must be discarded
        run_fetch(TMO - 1, 0, 1'b0, '0, 0, '0, 32'h3333_3333, dc, dn, rn, ao, aa, io, vo, eo, pd);
        n_cmp++; if (dc !== TMO + 1 || eo !== 1'b1) begin n_fail++; $display("FAIL tmo_late_gnt: got cyc %0d err %b, want %0d 1", dc, eo, TMO + 1); end
        // data arriving in the last allowed cycle is accepted
        run_fetch(2, TMO - 4, 1'b0, '0, 0, '0, 32'h4444_4444, dc, dn, rn, ao, aa, io, vo, eo, pd);
        n_cmp++; if (eo !== 1'b0 || io !== 32'h4444_4444) begin n_fail++; $display("FAIL tmo_edge_data: got err %b inst %h, want 0 %h", eo, io, 32'h4444_4444); end
        run_fetch(0, 0, 1'b0, '0, 0, '0, 32'h5555_5555, dc, dn, rn, ao, aa, io, vo, eo, pd);
        n_cmp++; if (eo !== 1'b0 || dc !== 3) begin n_fail++; $display("FAIL tmo_recover: got err %b cyc %0d, want 0 3", eo, dc); end
        n_cmp++; if (io !== 32'h5555_5555) begin n_fail++; $display("FAIL tmo_recover_inst: got %h, want %h", io, 32'h5555_5555); end
    endtask

    task automatic test_reset_mid_wait;
        set_pc(32'h40);
        n_cmp++; if (pc !== 32'h40) begin n_fail++; $display("FAIL rstw_pc_load: got %h, want %h", pc, 32'h40); end
        fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start  = 1'b0;
        bus.imem_gnt = 1'b1;
        @(posedge clk); #1;
        bus.imem_gnt = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rstw_pc: got %h, want %h", pc, 32'h0); end
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rstw_req: got %b, want 0", bus.imem_req); end
        n_cmp++; if (inst !== NOP) begin n_fail++; $display("FAIL rstw_inst: got %h, want %h", inst, NOP); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_valid: got %b, want 0", inst_valid); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.imem_rvalid = 1'b0;
        n_cmp++; if (inst !== NOP || inst_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_late_rvalid: got %h/%b, want %h/0", inst, inst_valid, NOP); end
        n_cmp++; if (fetch_done !== 1'b0) begin n_fail++; $display("FAIL rstw_done: got %b, want 0", fetch_done); end
        m_pc = 32'h0;
    endtask

    task automatic test_random;
        int dc, dn, rn, g, r, wc, ed;
        logic ao, vo, eo, sw, mis, er;
        logic [31:0] aa, io, pd, snpc, wnpc, data, addr, pc_exp;
        for (int i = 0; i < 30; i++) begin
            g    = $urandom_range(0, 9);
            r    = $urandom_range(0, 6);
            sw   = ($urandom_range(0, 2) == 0);
            snpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) snpc[1:0] = 2'($urandom_range(1, 3));
            wnpc = $urandom & 32'hFFFF_FFFC;
            data = $urandom;
            addr = sw ? snpc : m_pc;
            mis  = (addr[1:0] != 2'b00);
            ed   = exp_done(g, r, mis);
            er   = exp_err(g, r, mis);
            wc   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, ed) : 0;
            pc_exp = (wc > 0) ? wnpc : addr;
            run_fetch(g, r, sw, snpc, wc, wnpc, data, dc, dn, rn, ao, aa, io, vo, eo, pd);
            n_cmp++; if (dc !== ed) begin n_fail++; $display("FAIL rand%0d_done_cycle: got %0d, want %0d", i, dc, ed); end
            n_cmp++; if (dn !== 1) begin n_fail++; $display("FAIL rand%0d_done_pulses: got %0d, want 1", i, dn); end
            n_cmp++; if (rn !== exp_reqs(g, mis)) begin n_fail++; $display("FAIL rand%0d_req_cycles: got %0d, want %0d", i, rn, exp_reqs(g, mis)); end
            n_cmp++; if (eo !== er) begin n_fail++; $display("FAIL rand%0d_err: got %b, want %b", i, eo, er); end
            n_cmp++; if (io !== (er ? NOP : data)) begin n_fail++; $display("FAIL rand%0d_inst: got %h, want %h", i, io, er ? NOP : data); end
            n_cmp++; if (vo !== 1'b1) begin n_fail++; $display("FAIL rand%0d_valid: got %b, want 1", i, vo); end
            n_cmp++; if (pd !== addr) begin n_fail++; $display("FAIL rand%0d_pc_at_done: got %h, want %h", i, pd, addr); end
            n_cmp++; if (pc !== pc_exp) begin n_fail++; $display("FAIL rand%0d_pc_after: got %h, want %h", i, pc, pc_exp); end
            if (!mis) begin
                n_cmp++; if (aa !== addr || ao !== 1'b1) begin n_fail++; $display("FAIL rand%0d_addr: got %h stable %b, want %h", i, aa, ao, addr); end
            end
            m_pc = pc_exp;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        test_reset();
        test_basic();
        test_delayed();
        test_pending_pc();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
